// File: rtl/axis_rgb_unpacker.sv
// axis_rgb_unpacker: packed 24-bit RGB AXI-Stream in, planar byte stream out.
// Every frame is emitted as all R bytes, then all G bytes, then all B bytes.
// R bytes pass straight through, while the G and B planes are buffered and
// drained afterwards. The input is closed while the G and B planes drain.
// Optional feature: define AXIS_RGB_UNPACK_TLAST_CHECK_EN to check s_tlast
// against the pixel count and raise the sticky err_tlast flag on a mismatch.
module axis_rgb_unpacker #(
  parameter int unsigned IMG_PIXELS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_tvalid,
  input  logic [23:0] s_tdata,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic        m_tvalid,
  output logic [7:0]  m_tdata,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic        err_tlast
);

  localparam int unsigned AW       = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
  localparam logic [31:0] LAST_IDX = 32'(IMG_PIXELS - 1);

  typedef enum logic [1:0] {StR, StG, StB} state_e;

  state_e      state_q, state_d;
  logic [31:0] pix_idx_q, pix_idx_d;
  logic [31:0] rd_idx_q, rd_idx_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic [7:0]  m_tdata_q, m_tdata_d;
  logic        m_tlast_q, m_tlast_d;
  logic        slot_free, in_hs, buf_we;

  logic [7:0] g_buf [IMG_PIXELS];
  logic [7:0] b_buf [IMG_PIXELS];

  // The output register can take a new byte when empty or being drained.
  assign slot_free = !m_tvalid_q || m_tready;
  assign s_tready  = (state_q == StR) && slot_free;
  assign in_hs     = s_tvalid && s_tready;

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tlast  = m_tlast_q;

`ifdef AXIS_RGB_UNPACK_TLAST_CHECK_EN
  logic err_q, err_d;
  assign err_tlast = err_q;

  // Sticky flag: s_tlast must coincide with the last pixel by count.
  always_comb begin
    err_d = err_q;
    if (in_hs && (s_tlast != (pix_idx_q == LAST_IDX))) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_tlast;
  assign err_tlast    = 1'b0;
`endif

  // Next-state, index and output-register logic.
  always_comb begin
    state_d    = state_q;
    pix_idx_d  = pix_idx_q;
    rd_idx_d   = rd_idx_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    buf_we     = 1'b0;

    if (m_tvalid_q && m_tready) begin
      m_tvalid_d = 1'b0;
      m_tlast_d  = 1'b0;
    end

    unique case (state_q)
      StR: begin
        if (in_hs) begin
          m_tdata_d  = s_tdata[23:16];
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b0;
          buf_we     = 1'b1;
          if (pix_idx_q == LAST_IDX) begin
            pix_idx_d = '0;
            rd_idx_d  = '0;
            state_d   = StG;
          end else begin
            pix_idx_d = pix_idx_q + 32'd1;
          end
        end
      end
      StG: begin
        if (slot_free) begin
          m_tdata_d  = g_buf[rd_idx_q[AW-1:0]];
          m_tvalid_d = 1'b1;
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            state_d  = StB;
          end else begin
            rd_idx_d = rd_idx_q + 32'd1;
          end
        end
      end
      StB: begin
        if (slot_free) begin
          m_tdata_d  = b_buf[rd_idx_q[AW-1:0]];
          m_tvalid_d = 1'b1;
          m_tlast_d  = (rd_idx_q == LAST_IDX);
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            state_d  = StR;
          end else begin
            rd_idx_d = rd_idx_q + 32'd1;
          end
        end
      end
      default: state_d = StR;
    endcase
  end

  // State, index and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StR;
      pix_idx_q  <= '0;
      rd_idx_q   <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_idx_q  <= pix_idx_d;
      rd_idx_q   <= rd_idx_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

  // Plane buffers: written only in StR, read only in StG/StB, never reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      g_buf[pix_idx_q[AW-1:0]] <= s_tdata[15:8];
      b_buf[pix_idx_q[AW-1:0]] <= s_tdata[7:0];
    end
  end

endmodule

// File: tb/tb_axis_rgb_unpacker.sv
// Self-checking bench for axis_rgb_unpacker with a 4-pixel frame.
// Per-cycle vector table for two back-to-back frames, then hand-written
// sequences for mid-frame reset, output backpressure and the tlast check.
module tb_axis_rgb_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid;
  logic [23:0] s_tdata;
  logic        s_tlast;
  logic        s_tready;
  logic        m_tvalid;
  logic [7:0]  m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic        err_tlast;

  int n_vec = 0;
  int n_bad = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  axis_rgb_unpacker #(.IMG_PIXELS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tvalid  (s_tvalid),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .err_tlast (err_tlast)
  );

  typedef struct {
    logic        vld;
    logic [23:0] data;
    logic        last;
    logic        rdy;
    logic        e_sready;
    logic        e_mvalid;
    logic [7:0]  e_mdata;
    logic        e_mlast;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic vld, input logic [23:0] data, input logic last,
                     input logic rdy, input logic e_sready, input logic e_mvalid,
                     input logic [7:0] e_mdata, input logic e_mlast);
    vec_t v;
    v.vld = vld; v.data = data; v.last = last; v.rdy = rdy;
    v.e_sready = e_sready; v.e_mvalid = e_mvalid; v.e_mdata = e_mdata; v.e_mlast = e_mlast;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Push one 4-pixel frame and collect its 12 output bytes.
  task automatic run_frame(input logic [23:0] px [4], input bit toggle, input int tlast_at);
    logic [7:0] exp_b [12];
    int in_i = 0;
    int out_i = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic hs_in, hs_out;
    for (int p = 0; p < 4; p++) begin
      exp_b[p]     = px[p][23:16];
      exp_b[4 + p] = px[p][15:8];
      exp_b[8 + p] = px[p][7:0];
    end
    while (out_i < 12 && cyc < 200) begin
      @(negedge clk);
      m_tready = toggle ? (cyc % 2 == 0) : 1'b1;
      s_tvalid = (in_i < 4);
      s_tdata  = (in_i < 4) ? px[in_i] : 24'h0;
      s_tlast  = (in_i == tlast_at);
      if (prev_stall) chk("stall_hold", {24'h0, m_tdata}, {24'h0, prev_data});
      #1;
      hs_in  = s_tvalid && s_tready;
      hs_out = m_tvalid && m_tready;
      if (hs_out) begin
        chk($sformatf("byte%0d", out_i), {24'h0, m_tdata}, {24'h0, exp_b[out_i]});
        chk($sformatf("last%0d", out_i), {31'h0, m_tlast}, {31'h0, out_i == 11});
        out_i++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      @(posedge clk);
      if (hs_in) begin
`ifdef AXIS_RGB_UNPACK_TLAST_CHECK_EN
        if ((in_i == tlast_at) != (in_i == 3)) exp_err = 1'b1;
`endif
        in_i++;
        #1;
        chk("err_tlast", {31'h0, err_tlast}, {31'h0, exp_err});
      end
      cyc++;
    end
    if (out_i < 12) begin
      n_vec++;
      n_bad++;
      $display("FAIL frame_timeout: got %0d bytes expected 12", out_i);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
  endtask

  initial begin
    logic [23:0] f1 [4];
    logic [23:0] f3 [4];
    logic [23:0] f4 [4];
    f1 = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    f3 = '{24'hA1B2C3, 24'hD4E5F6, 24'h071829, 24'h3A4B5C};
    f4 = '{24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0};

    // Frame 1 at full rate: R plane, then 8 drain cycles with input closed.
    add(1, 24'h112233, 0, 1,  1, 1, 8'h11, 0);
    add(1, 24'h445566, 0, 1,  1, 1, 8'h44, 0);
    add(1, 24'h778899, 0, 1,  1, 1, 8'h77, 0);
    add(1, 24'hAABBCC, 1, 1,  1, 1, 8'hAA, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'h22, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'h55, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'h88, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'hBB, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'h33, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'h66, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'h99, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'hCC, 1);
    // Frame 2 back-to-back: first pixel taken while CC handshakes.
    add(1, 24'h010203, 0, 1,  1, 1, 8'h01, 0);
    add(1, 24'h010203, 0, 1,  1, 1, 8'h01, 0);
    add(1, 24'h010203, 0, 1,  1, 1, 8'h01, 0);
    add(1, 24'h010203, 1, 1,  1, 1, 8'h01, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'h02, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'h02, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'h02, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'h02, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'h03, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'h03, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'h03, 0);
    add(0, 24'h000000, 0, 1,  0, 1, 8'h03, 1);
    // Idle: output empties, data register holds the last byte.
    add(0, 24'h000000, 0, 1,  1, 0, 8'h03, 0);

    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mvalid", {31'h0, m_tvalid}, 32'h0);
    chk("rst_mdata", {24'h0, m_tdata}, 32'h0);
    chk("rst_mlast", {31'h0, m_tlast}, 32'h0);
    chk("rst_err", {31'h0, err_tlast}, 32'h0);
    chk("rst_sready", {31'h0, s_tready}, 32'h1);

    foreach (tbl[i]) begin
      @(negedge clk);
      s_tvalid = tbl[i].vld; s_tdata = tbl[i].data; s_tlast = tbl[i].last;
      m_tready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_sready", i), {31'h0, s_tready}, {31'h0, tbl[i].e_sready});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_mvalid", i), {31'h0, m_tvalid}, {31'h0, tbl[i].e_mvalid});
      chk($sformatf("v%0d_mdata", i), {24'h0, m_tdata}, {24'h0, tbl[i].e_mdata});
      chk($sformatf("v%0d_mlast", i), {31'h0, m_tlast}, {31'h0, tbl[i].e_mlast});
      chk($sformatf("v%0d_err", i), {31'h0, err_tlast}, 32'h0);
    end

    // Mid-frame reset after the 6th output byte (55).
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      s_tvalid = (c < 4); s_tdata = (c < 4) ? f1[c] : 24'h0; s_tlast = (c == 3);
      m_tready = 1'b1;
      @(posedge clk);
    end
    #1;
    chk("pre_rst_byte", {24'h0, m_tdata}, 32'h55);
    @(negedge clk);
    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_mvalid", {31'h0, m_tvalid}, 32'h0);
    chk("midrst_mdata", {24'h0, m_tdata}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_err = 1'b0;
    run_frame(f3, 1'b0, 3);

    // Backpressure with m_tready toggling 1,0,1,0.
    run_frame(f1, 1'b1, 3);

    // Misplaced s_tlast on pixel 2 raises err_tlast only when checking is built in.
    run_frame(f4, 1'b0, 1);
    repeat (3) @(posedge clk);
    #1;
`ifdef AXIS_RGB_UNPACK_TLAST_CHECK_EN
    chk("err_sticky", {31'h0, err_tlast}, 32'h1);
`else
    chk("err_sticky", {31'h0, err_tlast}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
